maint_tracker: RTL and testbench

MAINT_TRACKER -- requirements
Module: maint_tracker

---
 rtl/maint_pkg.sv | 5 +
 rtl/maint_channel.sv | 55 +++++
 rtl/maint_tracker.sv | 40 ++++
 tb/tb_maint_tracker.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/maint_pkg.sv
// maint_pkg: shared channel state encoding and locked-message constant
package maint_pkg;
  typedef enum logic [1:0] {RUN, SERVICE, LOCKED} state_t;
  localparam logic [31:0] MSG_LOCKED = '1;
endpackage

// File: rtl/maint_channel.sv
// maint_channel: one tracked channel with usage lockout and saturating maintenance count
module maint_channel
  import maint_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int LIMIT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             maint,
  input  logic             unlock,
  output logic             locked,
  output logic [CNT_W-1:0] mcnt
);
  // All-ones is reserved for the locked message, so the count stops one short
  localparam logic [CNT_W-1:0] SAT = ~CNT_W'(1);
  state_t state, state_n;
  logic [CNT_W-1:0] ucnt, ucnt_n, mcnt_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      ucnt <= '0;
      mcnt <= '0;
    end else begin
      state <= state_n;
      ucnt <= ucnt_n;
      mcnt <= mcnt_n;
    end
  end
  always_comb begin
    state_n = state;
    ucnt_n = ucnt;
    mcnt_n = mcnt;
    case (state)
      RUN:
        if (maint) begin
          state_n = SERVICE;
          ucnt_n = '0;
          mcnt_n = (mcnt == SAT) ? mcnt : mcnt + 1'b1;
        end else if (tick) begin
          state_n = (ucnt == CNT_W'(LIMIT - 1)) ? LOCKED : RUN;
          ucnt_n = ucnt + 1'b1;
        end
      SERVICE: state_n = RUN;
      LOCKED:
        if (unlock) begin
          state_n = RUN;
          ucnt_n = '0;
        end
      default: state_n = RUN;
    endcase
  end
  always_comb locked = (state == LOCKED);
endmodule

// File: rtl/maint_tracker.sv
// maint_tracker: N_CH independent maintenance channels with a selectable message port
module maint_tracker
  import maint_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  parameter int LIMIT = 200,
  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  use_i,
  input  logic [N_CH-1:0]  maint_i,
  input  logic [N_CH-1:0]  unlock_i,
  input  logic [SW-1:0]    sel_i,
  output logic [CNT_W-1:0] msg_o,
  output logic [N_CH-1:0]  locked_o,
  output logic             any_locked_o
);
  if (LIMIT < 1 || LIMIT > 2**CNT_W - 1) begin : g_bad_limit
    $error("maint_tracker: LIMIT out of range");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("maint_tracker: N_CH out of range");
  end
  logic [CNT_W-1:0] mcnt [N_CH];
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    maint_channel #(.CNT_W(CNT_W), .LIMIT(LIMIT)) u_ch (
      .clk(clk),
      .rst(rst),
      .tick(use_i[i]),
      .maint(maint_i[i]),
      .unlock(unlock_i[i]),
      .locked(locked_o[i]),
      .mcnt(mcnt[i])
    );
  end
  always_comb msg_o = (int'(sel_i) >= N_CH) ? '0 : locked_o[sel_i] ? MSG_LOCKED[CNT_W-1:0] : mcnt[sel_i];
  assign any_locked_o = |locked_o;
endmodule

// File: tb/tb_maint_tracker.sv
// tb_maint_tracker: scoreboard bench for maint_tracker with N_CH=4, CNT_W=8, LIMIT=5
module tb_maint_tracker;
  localparam int N = 4;
  localparam int LIM = 5;
  typedef struct {
    logic [3:0] locked;
    logic       any;
    logic [7:0] msg;
  } exp_t;
  logic       clk = 0;
  logic       rst;
  logic [3:0] use_i, maint_i, unlock_i;
  logic [1:0] sel_i;
  logic [7:0] msg_o;
  logic [3:0] locked_o;
  logic       any_locked_o;
  int checks = 0;
  int errors = 0;
  int st [N];
  int uc [N];
  int mc [N];
  exp_t q [$];
  maint_tracker #(.N_CH(N), .CNT_W(8), .LIMIT(LIM)) dut (
    .clk(clk),
    .rst(rst),
    .use_i(use_i),
    .maint_i(maint_i),
    .unlock_i(unlock_i),
    .sel_i(sel_i),
    .msg_o(msg_o),
    .locked_o(locked_o),
    .any_locked_o(any_locked_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Reference model: 0=RUN 1=SERVICE 2=LOCKED
  function automatic exp_t expect_now(input logic [1:0] s);
    exp_t e;
    for (int c = 0; c < N; c++) e.locked[c] = (st[c] == 2);
    e.any = |e.locked;
    e.msg = (st[s] == 2) ? 8'hFF : 8'(mc[s]);
    return e;
  endfunction
  task automatic step(input logic [3:0] u, input logic [3:0] m, input logic [3:0] ul,
                      input logic [1:0] s, input logic r, input string tag);
    exp_t e;
    use_i = u; maint_i = m; unlock_i = ul; sel_i = s; rst = r;
    for (int c = 0; c < N; c++) begin
      if (r) begin
        st[c] = 0; uc[c] = 0; mc[c] = 0;
      end else if (st[c] == 0) begin
        if (m[c]) begin
          st[c] = 1; uc[c] = 0; mc[c] = (mc[c] < 254) ? mc[c] + 1 : 254;
        end else if (u[c]) begin
          uc[c]++;
          if (uc[c] == LIM) st[c] = 2;
        end
      end else if (st[c] == 1) st[c] = 0;
      else if (ul[c]) begin
        st[c] = 0; uc[c] = 0;
      end
    end
    q.push_back(expect_now(s));
    @(posedge clk);
    #1;
    e = q.pop_front();
    check({tag, "_locked"}, locked_o, e.locked);
    check({tag, "_any"}, any_locked_o, e.any);
    check({tag, "_msg"}, msg_o, e.msg);
  endtask
  task automatic idle(input int n, input logic [1:0] s, input string tag);
    for (int k = 0; k < n; k++) step(4'h0, 4'h0, 4'h0, s, 1'b0, tag);
  endtask
  task automatic msg_at(input logic [1:0] s, input logic [7:0] exp, input string tag);
    sel_i = s;
    #1;
    check(tag, msg_o, exp);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    use_i = 0; maint_i = 0; unlock_i = 0; sel_i = 0; rst = 1;
    for (int c = 0; c < N; c++) begin st[c] = 0; uc[c] = 0; mc[c] = 0; end
    step(4'hF, 4'hF, 4'hF, 0, 1'b1, "rst0");
    step(4'hF, 4'hF, 4'hF, 0, 1'b1, "rst1");
    for (int s = 0; s < N; s++) msg_at(2'(s), 8'h00, "rst_msg");
    check("rst_locked", locked_o, 4'h0);
    // channel 0: one service, then five ticks lock it
    step(4'h0, 4'h1, 4'h0, 0, 1'b0, "svc0");
    idle(1, 0, "svc0_idle");
    check("svc0_msg", msg_o, 8'h01);
    for (int k = 0; k < 4; k++) step(4'h1, 4'h0, 4'h0, 0, 1'b0, "tick0");
    check("pre_lock0", locked_o, 4'h0);
    step(4'h1, 4'h0, 4'h0, 0, 1'b0, "tick0_5");
    check("lock0", locked_o, 4'h1);
    check("lock0_msg", msg_o, 8'hFF);
    check("lock0_any", any_locked_o, 1'b1);
    // locked channel ignores maint and use
    for (int k = 0; k < 3; k++) step(4'h1, 4'h1, 4'h0, 0, 1'b0, "lock0_hold");
    check("lock0_hold", locked_o, 4'h1);
    step(4'h0, 4'h0, 4'h1, 0, 1'b0, "unlock0");
    check("unlock0", locked_o, 4'h0);
    check("unlock0_msg", msg_o, 8'h01);
    for (int k = 0; k < 4; k++) step(4'h1, 4'h0, 4'h0, 0, 1'b0, "retick0");
    check("relock0_pre", locked_o, 4'h0);
    step(4'h1, 4'h0, 4'h0, 0, 1'b0, "retick0_5");
    check("relock0", locked_o, 4'h1);
    // channel 1: maint beats use, usage clears
    for (int k = 0; k < 3; k++) step(4'h2, 4'h0, 4'h0, 1, 1'b0, "tick1");
    step(4'h2, 4'h2, 4'h0, 1, 1'b0, "svc1");
    check("svc1_msg", msg_o, 8'h01);
    step(4'h2, 4'h2, 4'h2, 1, 1'b0, "svc1_ignore");
    check("svc1_ign_msg", msg_o, 8'h01);
    for (int k = 0; k < 4; k++) step(4'h2, 4'h0, 4'h0, 1, 1'b0, "tick1b");
    check("svc1_nolock", locked_o[1], 1'b0);
    // channel 2: maintenance count saturates short of all-ones
    for (int k = 0; k < 300; k++) begin
      step(4'h0, 4'h4, 4'h0, 2, 1'b0, "sat2");
      if (msg_o === 8'hFF) check("sat2_never_ff", msg_o, 8'hFE);
      step(4'h0, 4'h0, 4'h0, 2, 1'b0, "sat2_gap");
    end
    check("sat2_msg", msg_o, 8'hFE);
    check("sat2_lock", locked_o[2], 1'b0);
    // channel 3 locked, then reset clears everything
    for (int k = 0; k < LIM; k++) step(4'h8, 4'h0, 4'h0, 3, 1'b0, "tick3");
    check("lock3", locked_o[3], 1'b1);
    step(4'h2, 4'h2, 4'h0, 1, 1'b0, "svc_before_rst");
    step(4'hF, 4'hF, 4'hF, 3, 1'b1, "rst_mid");
    check("rst_mid_locked", locked_o, 4'h0);
    for (int s = 0; s < N; s++) msg_at(2'(s), 8'h00, "rst_mid_msg");
    for (int k = 0; k < 4; k++) step(4'h8, 4'h0, 4'h0, 3, 1'b0, "tick3r");
    check("tick3r_pre", locked_o[3], 1'b0);
    step(4'h8, 4'h0, 4'h0, 3, 1'b0, "tick3r_5");
    check("tick3r_lock", locked_o[3], 1'b1);
    // all channels together, staggered release
    step(4'h0, 4'h0, 4'h0, 0, 1'b1, "rst2");
    for (int k = 0; k < 4; k++) step(4'hF, 4'h0, 4'h0, 0, 1'b0, "all");
    check("all_pre", locked_o, 4'h0);
    step(4'hF, 4'h0, 4'h0, 0, 1'b0, "all5");
    check("all_lock", locked_o, 4'hF);
    step(4'h0, 4'h0, 4'h1, 0, 1'b0, "stag0");
    check("stag0", locked_o, 4'hE);
    step(4'h1, 4'h0, 4'h4, 2, 1'b0, "stag2");
    check("stag2", locked_o, 4'hA);
    step(4'h0, 4'h0, 4'h8, 3, 1'b0, "stag3");
    check("stag3", locked_o, 4'h2);
    msg_at(2'd1, 8'hFF, "stag_msg1");
    // random traffic against the model
    for (int k = 0; k < 300; k++)
      step(4'($urandom), 4'($urandom) & 4'($urandom), 4'($urandom), 2'($urandom),
           ($urandom_range(0, 40) == 0), "rand");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
